// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check controller.
// The state encoding and timer sizing helper live here so the top and the timer agree on them.
package sysid_check_pkg;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hACD5_1314;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h594D_7BAE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID_REQ,
    ST_RD_ID_WAIT,
    ST_RD_TS_REQ,
    ST_RD_TS_WAIT,
    ST_COMPARE,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Bits needed to hold the values 0..max_count.
  function automatic int unsigned timer_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read-only master link between the check controller and the sysid slave.
// The master drives address/read; the interconnect answers with waitrequest and pipelined data.
interface sysid_check_ctrl_if;

  logic        address;
  logic        read;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdatavalid,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdatavalid,
    output readdata
  );

endinterface

// File: rtl/sysid_check_timer.sv
// Loadable response-timeout down-counter.
// expired_o flags the enabled cycle in which the count would reach zero.
module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned WIDTH     = timer_width(MAX_COUNT)
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = WIDTH'(MAX_COUNT);
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Firing on the last non-zero value gives exactly MAX_COUNT waiting cycles after a load.
  assign expired_o = en_i && (count_q == WIDTH'(1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID check: reads the sysid ID and timestamp words over Avalon-MM,
// retries on response timeout and reports match/timeout status with registered outputs.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  sysid_check_ctrl_if.master        avm,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      id_match_o,
  output logic                      ts_match_o,
  output logic                      pass_o,
  output logic                      timeout_err_o,
  output logic [31:0]               id_value_o,
  output logic [31:0]               ts_value_o
);

  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  state_e      state_q;
  logic        read_q;
  logic        addr_q;
  logic        busy_q;
  logic        done_q;
  logic        id_match_q;
  logic        ts_match_q;
  logic        pass_q;
  logic        timeout_err_q;
  logic [31:0] id_value_q;
  logic [31:0] ts_value_q;
  logic [3:0]  retry_q;
  logic        auto_q;

  logic timer_load;
  logic timer_en;
  logic timer_expired;
  logic in_req;
  logic in_wait;
  logic id_eq;
  logic ts_eq;

  assign in_req  = (state_q == ST_RD_ID_REQ)  || (state_q == ST_RD_TS_REQ);
  assign in_wait = (state_q == ST_RD_ID_WAIT) || (state_q == ST_RD_TS_WAIT);
  assign id_eq   = (id_value_q == EXPECTED_ID);
  assign ts_eq   = (ts_value_q == EXPECTED_TS);

  // A response on the expiry cycle takes priority, so the timer only counts silent cycles.
  assign timer_load = in_req && !avm.waitrequest;
  assign timer_en   = in_wait && !avm.readdatavalid;

  sysid_check_timer #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .load_i    (timer_load),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      read_q        <= 1'b0;
      addr_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      retry_q       <= '0;
      auto_q        <= AUTO_START;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_i || auto_q) begin
            auto_q        <= 1'b0;
            state_q       <= ST_RD_ID_REQ;
            read_q        <= 1'b1;
            addr_q        <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            pass_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            retry_q       <= '0;
          end
        end

        ST_RD_ID_REQ, ST_RD_TS_REQ: begin
          if (!avm.waitrequest) begin
            state_q <= (state_q == ST_RD_ID_REQ) ? ST_RD_ID_WAIT : ST_RD_TS_WAIT;
            read_q  <= 1'b0;
          end
        end

        ST_RD_ID_WAIT, ST_RD_TS_WAIT: begin
          if (avm.readdatavalid) begin
            if (state_q == ST_RD_ID_WAIT) begin
              id_value_q <= avm.readdata;
              state_q    <= ST_RD_TS_REQ;
              read_q     <= 1'b1;
              addr_q     <= 1'b1;
              retry_q    <= '0;
            end else begin
              ts_value_q <= avm.readdata;
              state_q    <= ST_COMPARE;
            end
          end else if (timer_expired) begin
            if (retry_q < MAX_RETRY_L) begin
              retry_q <= retry_q + 4'd1;
              state_q <= (state_q == ST_RD_ID_WAIT) ? ST_RD_ID_REQ : ST_RD_TS_REQ;
              read_q  <= 1'b1;
            end else begin
              state_q       <= ST_FAIL;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              timeout_err_q <= 1'b1;
            end
          end
        end

        ST_COMPARE: begin
          state_q    <= ST_DONE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          id_match_q <= id_eq;
          ts_match_q <= ts_eq;
          pass_q     <= id_eq && (ts_eq || !CHECK_TS);
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm.read      = read_q;
  assign avm.address   = addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign id_match_o    = id_match_q;
  assign ts_match_o    = ts_match_q;
  assign pass_o        = pass_q;
  assign timeout_err_o = timeout_err_q;
  assign id_value_o    = id_value_q;
  assign ts_value_o    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: DUT0 checks the timestamp with a short timeout, DUT1 only captures it.
// Both share clock, reset and start; each has its own small sysid slave model.
`timescale 1ns/1ps
module tb_sysid_check_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  sysid_check_ctrl_if bus0 ();
  sysid_check_ctrl_if bus1 ();

  logic [1:0]  busy, done, idm, tsm, pass, terr;
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  sysid_check_ctrl #(
    .CHECK_TS(1'b1), .TIMEOUT_CYCLES(8), .MAX_RETRY(2), .AUTO_START(1'b1)
  ) dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .avm(bus0),
    .busy_o(busy[0]), .done_o(done[0]), .id_match_o(idm[0]), .ts_match_o(tsm[0]),
    .pass_o(pass[0]), .timeout_err_o(terr[0]), .id_value_o(idv[0]), .ts_value_o(tsv[0])
  );

  sysid_check_ctrl #(
    .CHECK_TS(1'b0)
  ) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .avm(bus1),
    .busy_o(busy[1]), .done_o(done[1]), .id_match_o(idm[1]), .ts_match_o(tsm[1]),
    .pass_o(pass[1]), .timeout_err_o(terr[1]), .id_value_o(idv[1]), .ts_value_o(tsv[1])
  );

  // Slave configuration (written by the stimulus process only)
  logic [31:0] id_data = 32'hACD5_1314;
  logic [31:0] ts_data = 32'h594D_7BAE;
  int   sess_cfg = 0, wr_cfg = 0, drop_cfg = 0, ts_delay = 1;
  logic stray = 1'b0;

  // Slave state (written by the slave process only)
  int   cyc = 0, sess_seen = 0, wr_left = 0, drop_left = 0, pend = 0;
  int   acc_id = 0, acc_ts = 0;
  int   ts_acc_at [64];
  logic rdv0_q = 1'b0;
  logic [31:0] rdata0_q = '0, pend_data = '0;

  assign bus0.waitrequest   = bus0.read && (wr_left != 0);
  assign bus0.readdatavalid = rdv0_q | stray;
  assign bus0.readdata      = stray ? 32'hDEAD_BEEF : rdata0_q;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rdv0_q <= 1'b0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        rdv0_q   <= 1'b1;
        rdata0_q <= pend_data;
      end
    end
    if (bus0.read && wr_left != 0) begin
      wr_left <= wr_left - 1;
    end else if (bus0.read) begin
      if (bus0.address == 1'b0) begin
        acc_id   <= acc_id + 1;
        rdv0_q   <= 1'b1;
        rdata0_q <= id_data;
      end else begin
        acc_ts <= acc_ts + 1;
        ts_acc_at[acc_ts % 64] <= cyc;
        if (drop_left != 0) begin
          drop_left <= drop_left - 1;
        end else if (ts_delay <= 1) begin
          rdv0_q   <= 1'b1;
          rdata0_q <= ts_data;
        end else begin
          pend      <= ts_delay - 1;
          pend_data <= ts_data;
        end
      end
    end
    if (sess_seen != sess_cfg) begin
      sess_seen <= sess_cfg;
      wr_left   <= wr_cfg;
      drop_left <= drop_cfg;
    end
  end

  // DUT1 slave: never stalls, answers one cycle after every accepted read
  logic rdv1_q = 1'b0;
  logic [31:0] rdata1_q = '0;
  assign bus1.waitrequest   = 1'b0;
  assign bus1.readdatavalid = rdv1_q;
  assign bus1.readdata      = rdata1_q;
  always @(posedge clk) begin
    rdv1_q   <= bus1.read;
    rdata1_q <= bus1.address ? ts_data : id_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int waited);
    waited = 0;
    while (!(done[0] === 1'b1 && done[1] === 1'b1) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_done_in_time"}, 32'(waited < limit), 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_read"},  bus0.read,    0);
    chk({tag, "_addr"},  bus0.address, 0);
    chk({tag, "_busy"},  busy[0], 0);
    chk({tag, "_done"},  done[0], 0);
    chk({tag, "_idm"},   idm[0],  0);
    chk({tag, "_tsm"},   tsm[0],  0);
    chk({tag, "_pass"},  pass[0], 0);
    chk({tag, "_terr"},  terr[0], 0);
    chk({tag, "_idv"},   idv[0],  0);
    chk({tag, "_tsv"},   tsv[0],  0);
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        idm;
    logic        tsm;
    logic        pass0;
    logic        pass1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, a_id, a_ts;
    logic [31:0] prev_id;

    vecs[0] = '{32'hACD5_1314, 32'h594D_7BAE, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'hACD5_1315, 32'h594D_7BAE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hACD5_1314, 32'h594D_7BAF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hACD5_1314, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values, then the automatic check with a zero-wait slave
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("c1_read", bus0.read, 1); chk("c1_addr", bus0.address, 0); chk("c1_busy", busy[0], 1);
    @(negedge clk);
    chk("c2_read", bus0.read, 0); chk("c2_busy", busy[0], 1);
    @(negedge clk);
    chk("c3_read", bus0.read, 1); chk("c3_addr", bus0.address, 1);
    @(negedge clk);
    chk("c4_read", bus0.read, 0);
    @(negedge clk);
    chk("c5_done", done[0], 0); chk("c5_busy", busy[0], 1);
    @(negedge clk);
    chk("c6_done", done[0], 1); chk("c6_busy", busy[0], 0); chk("c6_pass", pass[0], 1);
    chk("c6_terr", terr[0], 0); chk("c6_idv", idv[0], 32'hACD5_1314); chk("c6_tsv", tsv[0], 32'h594D_7BAE);
    chk("auto_id_reads", acc_id, 1); chk("auto_ts_reads", acc_ts, 1);
    @(negedge clk);
    chk("c7_done_sticky", done[0], 1); chk("c7_pass_sticky", pass[0], 1);
    $display("auto-start: done at cycle 6, pass=%b", pass[0]);

    // Table-driven checks, each restarted from DONE
    prev_id = 32'hACD5_1314;
    for (int i = 0; i < 5; i++) begin
      id_data = vecs[i].id;
      ts_data = vecs[i].ts;
      pulse_start();
      chk($sformatf("v%0d_c1_done", i), done[0], 0);
      chk($sformatf("v%0d_c1_pass", i), pass[0], 0);
      chk($sformatf("v%0d_c1_idm", i),  idm[0],  0);
      chk($sformatf("v%0d_c1_busy", i), busy[0], 1);
      chk($sformatf("v%0d_c1_idv_hold", i), idv[0], prev_id);
      wait_done($sformatf("v%0d", i), 40, waited);
      chk($sformatf("v%0d_latency", i), waited, 5);
      chk($sformatf("v%0d_idm", i),   idm[0],  vecs[i].idm);
      chk($sformatf("v%0d_tsm", i),   tsm[0],  vecs[i].tsm);
      chk($sformatf("v%0d_pass0", i), pass[0], vecs[i].pass0);
      chk($sformatf("v%0d_terr", i),  terr[0], 0);
      chk($sformatf("v%0d_idv", i),   idv[0],  vecs[i].id);
      chk($sformatf("v%0d_tsv", i),   tsv[0],  vecs[i].ts);
      chk($sformatf("v%0d_pass1", i), pass[1], vecs[i].pass1);
      chk($sformatf("v%0d_tsm1", i),  tsm[1],  vecs[i].tsm);
      $display("vector %0d: id=%h ts=%h idm=%b tsm=%b pass0=%b pass1=%b",
               i, vecs[i].id, vecs[i].ts, idm[0], tsm[0], pass[0], pass[1]);
      prev_id = vecs[i].id;
    end
    id_data = 32'hACD5_1314;
    ts_data = 32'h594D_7BAE;

    // waitrequest held for 5 cycles on the ID read
    wr_cfg = 5; drop_cfg = 0; sess_cfg++;
    a_id = acc_id; a_ts = acc_ts;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ws_k%0d_read", k), bus0.read, 1);
      chk($sformatf("ws_k%0d_addr", k), bus0.address, 0);
      @(negedge clk);
    end
    chk("ws_read_dropped", bus0.read, 0);
    wait_done("ws", 40, waited);
    chk("ws_latency", waited, 4);
    chk("ws_id_reads", acc_id - a_id, 1); chk("ws_ts_reads", acc_ts - a_ts, 1);
    chk("ws_pass", pass[0], 1);
    $display("waitrequest stall: id reads=%0d ts reads=%0d pass=%b", acc_id - a_id, acc_ts - a_ts, pass[0]);

    // Start while busy is ignored
    wr_cfg = 0; sess_cfg++;
    a_id = acc_id; a_ts = acc_ts;
    pulse_start();
    pulse_start();
    wait_done("busy_start", 40, waited);
    chk("busy_start_latency", waited, 4);
    chk("busy_start_id_reads", acc_id - a_id, 1); chk("busy_start_ts_reads", acc_ts - a_ts, 1);
    $display("start while busy: done after %0d cycles, id reads=%0d", waited + 1, acc_id - a_id);

    // TS slave silent: three TS reads 9 cycles apart, then FAIL
    drop_cfg = 3; sess_cfg++;
    a_ts = acc_ts;
    pulse_start();
    wait_done("to", 200, waited);
    chk("to_latency", waited, 29);
    chk("to_ts_reads", acc_ts - a_ts, 3);
    chk("to_gap1", ts_acc_at[(a_ts + 1) % 64] - ts_acc_at[a_ts % 64], 9);
    chk("to_gap2", ts_acc_at[(a_ts + 2) % 64] - ts_acc_at[(a_ts + 1) % 64], 9);
    chk("to_terr", terr[0], 1); chk("to_done", done[0], 1);
    chk("to_pass", pass[0], 0); chk("to_busy", busy[0], 0);
    $display("timeout: ts reads=%0d terr=%b done=%b", acc_ts - a_ts, terr[0], done[0]);

    // Restart from FAIL; response on the second retry lands on the expiry cycle
    drop_cfg = 2; ts_delay = 8; sess_cfg++;
    a_ts = acc_ts;
    pulse_start();
    chk("late_c1_terr", terr[0], 0); chk("late_c1_done", done[0], 0); chk("late_c1_busy", busy[0], 1);
    wait_done("late", 200, waited);
    chk("late_latency", waited, 30);
    chk("late_ts_reads", acc_ts - a_ts, 3);
    chk("late_pass", pass[0], 1); chk("late_terr", terr[0], 0);
    $display("late response: ts reads=%0d pass=%b terr=%b", acc_ts - a_ts, pass[0], terr[0]);
    ts_delay = 1;

    // Reset while waiting on the TS word, stray response, clean automatic rerun
    drop_cfg = 1; sess_cfg++;
    pulse_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("rst_mid");
    rst = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    chk("rst_stray_read", bus0.read, 1);
    @(negedge clk);
    stray = 1'b0;
    wait_done("rst_rerun", 40, waited);
    chk("rst_rerun_latency", waited, 4);
    chk("rst_rerun_idv", idv[0], 32'hACD5_1314);
    chk("rst_rerun_pass", pass[0], 1); chk("rst_rerun_terr", terr[0], 0);
    $display("reset mid-read: rerun idv=%h pass=%b", idv[0], pass[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Avalon-MM master controller that sequences reads of the system-ID control slave: word 0 (ID) and word 1 (build timestamp). It compares both words against the values the HPS software stack was built for and reports match/mismatch plus timeout status to the reset/boot logic and a CSR bank. It sits between the boot sequencer and the sysid slave through the interconnect, so pipelined responses (waitrequest, readdatavalid) are handled.

## Interface
- EXPECTED_ID, 32'hACD5_1314, ID value expected at address 0
- EXPECTED_TS, 32'h594D_7BAE, timestamp expected at address 1
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp only captured
- TIMEOUT_CYCLES, 255, max cycles from read accept to readdatavalid (1..65535)
- MAX_RETRY, 3, reissues per word after timeout (0..15)
- AUTO_START, 1, start a check automatically on the first cycle after reset
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to (re)run the check; honoured only in IDLE, DONE, FAIL
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  interconnect stall
- avm_readdatavalid  in  1  response valid
- avm_readdata  in  32  response data
- busy  out  1  check in progress
- done  out  1  check finished, sticky until next start or reset
- id_match  out  1  captured ID equals EXPECTED_ID
- ts_match  out  1  captured timestamp equals EXPECTED_TS
- pass  out  1  done & id_match & (ts_match | ~CHECK_TS)
- timeout_err  out  1  a word exhausted its retries
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

## Operation
- States: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, COMPARE, DONE, FAIL.
- IDLE: on start (or the first post-reset cycle if AUTO_START) -> RD_ID_REQ; clear id/ts_match, done, timeout_err; retry count = 0.
- x_REQ: avm_read=1, avm_address constant. Stay while avm_waitrequest=1. When accepted -> x_WAIT; load timeout counter with TIMEOUT_CYCLES.
- x_WAIT: avm_read=0. On avm_readdatavalid, capture avm_readdata into id_value/ts_value. RD_ID_WAIT -> RD_TS_REQ (retry count cleared). RD_TS_WAIT -> COMPARE.
- Timeout: counter decrements each WAIT cycle without readdatavalid. At zero with retries < MAX_RETRY: increment retries, back to the same x_REQ. Otherwise -> FAIL with timeout_err=1.
- COMPARE: register id_match, ts_match -> DONE.
- DONE/FAIL: done=1 (FAIL too), busy=0; start -> RD_ID_REQ with flags cleared as in IDLE.
- readdatavalid outside x_WAIT is ignored; start while busy is ignored.
- id_value/ts_value hold their last captured value across restarts until overwritten.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_match=0, ts_match=0, pass=0, timeout_err=0, id_value=0, ts_value=0; state IDLE.
- Reset mid-transaction: avm_read low in the cycle after reset is sampled high. Outstanding responses are dropped.
- All outputs registered. busy is high from the cycle after start is sampled until the cycle DONE/FAIL is entered.
- Zero-wait slave with readdatavalid one cycle after accept: start sampled at edge 0. Read of ID at cycle 1, of TS at cycle 3, COMPARE at cycle 5, done=1 from cycle 6.
- Timeout fires exactly TIMEOUT_CYCLES cycles after accept with no readdatavalid. If readdatavalid arrives on the expiry cycle, the data is accepted and no retry occurs.
- Worst-case check duration is bounded by 2·(MAX_RETRY+1)·(TIMEOUT_CYCLES+1) plus waitrequest stalls.

## Structure
- Package sysid_check_pkg: state enum, default EXPECTED_ID/EXPECTED_TS constants, counter width function (clog2 of TIMEOUT_CYCLES+1).
- Sub-module sysid_check_timer: loadable down-counter with load, enable, expired outputs. The FSM, capture registers and compare stay in the top.

## Test plan
- Zero-wait slave returning 0xACD51314 / 0x594D7BAE, AUTO_START -> two reads at addresses 0 then 1; done at cycle 6; pass=1, timeout_err=0.
- Slave returns ID 0xACD51315 -> done=1, id_match=0, pass=0. Repeat with CHECK_TS=0 and a wrong timestamp -> pass=1, ts_match=0.
- waitrequest held 5 cycles on the ID read -> avm_read/address stable throughout; exactly one accepted read per word.
- TIMEOUT_CYCLES=8, MAX_RETRY=2, slave never responds on the TS read -> three TS reads 9 cycles apart, then FAIL; timeout_err=1, done=1. One late response on the second retry -> pass.
- Reset asserted during RD_TS_WAIT -> avm_read=0, all flags 0 next cycle. A stray readdatavalid afterwards is ignored, and AUTO_START reruns cleanly.
- start pulsed while busy -> ignored; start pulsed in DONE -> full rerun with flags cleared on the first cycle.
